chopper_sequencer: RTL and testbench
====================================

// Module: chopper_sequencer
// PURPOSE
//  Schedules the lock-in chopper: generates the quadrature reference pair (ref_i/ref_q) at a programmable rate.
//  Runs for a programmed number of reference periods, then reports completion.
//  Emits per-quadrant sample-valid strobes, with a post-edge blanking window, to the demodulator/accumulator.
//  Sits between the host control registers and the demodulation datapath.
// PARAMETERS
//  DIV_W    16  width of quarter-period length (clk_in ticks per quadrant)
//  CNT_W    16  width of period count / period counter
//  BLANK_W   8  width of blanking length
// PORTS
//  clk_in           in   1        single system clock; all logic on posedge
//  rst_in           in   1        asynchronous, active-high reset
//  start_in         in   1        start request (level, sampled in IDLE only)
//  stop_in          in   1        graceful stop request (sampled in RUN only)
//  quarter_len_in   in   DIV_W    ticks per quadrant; latched at start; 0 treated as 1
//  n_periods_in     in   CNT_W    periods to run; latched at start
//  blank_in         in   BLANK_W  ticks suppressed after each quadrant edge; latched at start
//  busy_out         out  1        high in RUN and DRAIN
//  done_out         out  1        one-cycle pulse at end of sequence
//  ref_i_out        out  1        in-phase chopper reference
//  ref_q_out        out  1        quadrature chopper reference (lags ref_i by one quadrant)
//  quadrant_out     out  2        current quadrant 0..3
//  sample_valid_out out  1        high on non-blanked ticks of a quadrant
//  period_cnt_out   out  CNT_W    completed periods in current sequence
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, FSM=IDLE, counters 0; reset mid-run aborts, no done pulse.
//  All outputs registered.
//  FSM: IDLE -start-> RUN; RUN -stop-> DRAIN; RUN/DRAIN -last tick of q3 (terminating)-> DONE; DONE -> IDLE (1 cycle).
//  Start with latched N=0: IDLE -> DONE directly; no ref activity.
//  Start in IDLE at edge k: busy_out=1, quadrant=0, ref_i=1, tick=0 visible after edge k+1.
//  Quadrant map (ref_i,ref_q): q0=(1,0) q1=(1,1) q2=(0,1) q3=(0,0); IDLE/DONE drive (0,0).
//  tick counter 0..Q-1 (Q=max(quarter_len,1)); at tick==Q-1: tick->0, quadrant+1 mod 4.
//  At end of q3: period_cnt+1.
//  Terminating: period_cnt+1==N, or state==DRAIN. Terminating -> DONE, refs (0,0), busy_out=0, done_out=1 for one cycle.
//  period_cnt_out holds its final value until next start (cleared on start).
//  sample_valid_out = busy && tick>=blank. blank>=Q -> no samples in any quadrant. blank=0 -> every tick valid.
//  stop_in in DRAIN ignored; start_in outside IDLE ignored.
//  start_in and stop_in same cycle in IDLE: start wins.
//  stop_in on the last tick of q3: that period completes, then DONE. No extra period.
//  Comparisons unsigned; tick is DIV_W bits, blank zero-extended to DIV_W.
//  Inputs are ignored while busy (latched copies used).
// CONFIGURATION
//  CHOPPER_CONTINUOUS_EN defined: N=0 means free-run; run until stop_in, then DRAIN. period_cnt wraps modulo 2^CNT_W.
//  CHOPPER_CONTINUOUS_EN undefined: N=0 gives immediate DONE (see above); period_cnt never wraps.
// STRUCTURE
//  Package lockin_pkg: FSM state typedef (IDLE, RUN, DRAIN, DONE); quadrant-to-(ref_i,ref_q) constant table.
//  Sub-module chop_tick_counter: tick/quadrant counter with load and wrap pulse.
//  FSM, period count and blanking compare stay in the top module.
// TESTING
//  Q=4, N=2, blank=1, start 1 cycle -> ref_i 1,1,1,1,1,1,1,1,0x8 per period; busy 32 cycles.
//    Also: sample_valid 3/4 ticks; done pulse at cycle 33; period_cnt_out=2.
//  Q=0, N=1, blank=0 -> Q treated as 1; quadrant 0,1,2,3 on consecutive cycles; done after 4 cycles.
//  Q=8, N=5, stop_in pulse at tick 3 of q1 in period 0 -> period 0 finishes; done; period_cnt_out=1.
//  Q=4, blank=4 -> sample_valid_out never asserts while refs toggle normally.
//  N=0 -> without CHOPPER_CONTINUOUS_EN: done next cycle, refs stay 0.
//    With CHOPPER_CONTINUOUS_EN: runs until stop, then DRAIN finishes the period.
//  rst_in pulsed mid-q2 -> all outputs 0 immediately, no done; new start then runs normally.

Source files
------------

// File: rtl/lockin_pkg.sv
// Shared types for the lock-in chopper: sequencer FSM states and the
// quadrant-to-reference lookup.
package lockin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chop_state_t;

  // Packed {ref_i,ref_q} per quadrant, q3 in the top pair down to q0 in the bottom pair.
  localparam logic [7:0] REF_MAP = 8'b00_01_11_10;

  function automatic logic [1:0] ref_pair(input logic [1:0] quad);
    logic [7:0] map;
    map = REF_MAP;
    return map[{quad, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/chop_tick_counter.sv
// Tick/quadrant counter for the chopper: counts 0..q_len-1 per quadrant,
// flags the last tick of each quadrant and of each full period.
module chop_tick_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] q_len,
  output logic [DIV_W-1:0] tick,
  output logic [1:0]       quadrant,
  output logic             quad_last,
  output logic             period_wrap
);

  logic [DIV_W-1:0] tick_reg;
  logic [1:0]       quad_reg;

  // q_len is never 0 here; the top clamps it to at least 1 when latching.
  assign quad_last   = en && (tick_reg == q_len - DIV_W'(1));
  assign period_wrap = quad_last && (quad_reg == 2'd3);
  assign tick        = tick_reg;
  assign quadrant    = quad_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tick_reg <= '0;
      quad_reg <= '0;
    end else if (load) begin
      tick_reg <= '0;
      quad_reg <= '0;
    end else if (en) begin
      if (quad_last) begin
        tick_reg <= '0;
        quad_reg <= quad_reg + 2'd1;
      end else begin
        tick_reg <= tick_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/chopper_sequencer.sv
// Lock-in chopper sequencer: quadrature reference generation, period counting,
// blanked sample strobes. Define CHOPPER_CONTINUOUS_EN to make N=0 free-running.
module chopper_sequencer
  import lockin_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16,
  parameter int BLANK_W = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic [DIV_W-1:0]   quarter_len_in,
  input  logic [CNT_W-1:0]   n_periods_in,
  input  logic [BLANK_W-1:0] blank_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               ref_i_out,
  output logic               ref_q_out,
  output logic [1:0]         quadrant_out,
  output logic               sample_valid_out,
  output logic [CNT_W-1:0]   period_cnt_out
);

  chop_state_t        state_reg, state_next;
  logic [DIV_W-1:0]   q_len_reg;
  logic [CNT_W-1:0]   n_reg;
  logic [BLANK_W-1:0] blank_reg;
  logic [CNT_W-1:0]   period_cnt_reg;

  logic               start_hit;
  logic               active;
  logic               last_period;
  logic [DIV_W-1:0]   tick;
  logic [1:0]         quadrant;
  logic               quad_last;
  logic               period_wrap;
  logic [1:0]         ref_next;

  assign start_hit = (state_reg == ST_IDLE) && start_in;
  assign active    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign ref_next  = active ? ref_pair(quadrant) : 2'b00;

  chop_tick_counter #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load        (start_hit),
    .en          (active),
    .q_len       (q_len_reg),
    .tick        (tick),
    .quadrant    (quadrant),
    .quad_last   (quad_last),
    .period_wrap (period_wrap)
  );

`ifdef CHOPPER_CONTINUOUS_EN
  // N=0 free-runs; the counter may wrap, so it must never match a zero target.
  assign last_period = (n_reg != '0) && (period_cnt_reg + CNT_W'(1) == n_reg);
`else
  assign last_period = (period_cnt_reg + CNT_W'(1) == n_reg);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) begin
`ifdef CHOPPER_CONTINUOUS_EN
          state_next = ST_RUN;
`else
          state_next = (n_periods_in == '0) ? ST_DONE : ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        // A stop on the final tick of q3 ends here rather than draining a further period.
        if (period_wrap && (last_period || stop_in)) state_next = ST_DONE;
        else if (stop_in)                            state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (period_wrap) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= ST_IDLE;
      q_len_reg      <= DIV_W'(1);
      n_reg          <= '0;
      blank_reg      <= '0;
      period_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_hit) begin
        q_len_reg      <= (quarter_len_in == '0) ? DIV_W'(1) : quarter_len_in;
        n_reg          <= n_periods_in;
        blank_reg      <= blank_in;
        period_cnt_reg <= '0;
      end else if (period_wrap) begin
        period_cnt_reg <= period_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Output stage: one-cycle registered view of the sequencer state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      ref_i_out        <= 1'b0;
      ref_q_out        <= 1'b0;
      quadrant_out     <= 2'd0;
      sample_valid_out <= 1'b0;
      period_cnt_out   <= '0;
    end else begin
      busy_out         <= active;
      done_out         <= (state_reg == ST_DONE);
      ref_i_out        <= ref_next[1];
      ref_q_out        <= ref_next[0];
      quadrant_out     <= active ? quadrant : 2'd0;
      sample_valid_out <= active && (tick >= DIV_W'(blank_reg));
      period_cnt_out   <= period_cnt_reg;
    end
  end

endmodule

// File: tb/tb_chopper_sequencer.sv
// Directed self-checking bench for chopper_sequencer; expected waveforms are
// derived from quadrant/tick arithmetic per test step.
module tb_chopper_sequencer;

  localparam int DIV_W   = 16;
  localparam int CNT_W   = 16;
  localparam int BLANK_W = 8;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               start_in;
  logic               stop_in;
  logic [DIV_W-1:0]   quarter_len_in;
  logic [CNT_W-1:0]   n_periods_in;
  logic [BLANK_W-1:0] blank_in;
  logic               busy_out;
  logic               done_out;
  logic               ref_i_out;
  logic               ref_q_out;
  logic [1:0]         quadrant_out;
  logic               sample_valid_out;
  logic [CNT_W-1:0]   period_cnt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  chopper_sequencer #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .BLANK_W(BLANK_W)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .stop_in          (stop_in),
    .quarter_len_in   (quarter_len_in),
    .n_periods_in     (n_periods_in),
    .blank_in         (blank_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .ref_i_out        (ref_i_out),
    .ref_q_out        (ref_q_out),
    .quadrant_out     (quadrant_out),
    .sample_valid_out (sample_valid_out),
    .period_cnt_out   (period_cnt_out)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"},  32'(busy_out), 0);
    chk({tag, " done"},  32'(done_out), 0);
    chk({tag, " ref_i"}, 32'(ref_i_out), 0);
    chk({tag, " ref_q"}, 32'(ref_q_out), 0);
    chk({tag, " quad"},  32'(quadrant_out), 0);
    chk({tag, " sv"},    32'(sample_valid_out), 0);
    chk({tag, " pcnt"},  32'(period_cnt_out), 0);
  endtask

  // Start a sequence and follow it cycle by cycle. stop_tick >= 0 asserts
  // stop_in so it is sampled while that state tick is current.
  task automatic run_seq(input int qin, input int nin, input int bin, input int stop_tick,
                         input bit stop_with_start, input string tag);
    int qe, per_len, periods, total, sp;
    int t, tq, quad, per;
    string nm;
    qe      = (qin == 0) ? 1 : qin;
    per_len = 4 * qe;
    periods = nin;
    if (stop_tick >= 0) begin
      sp = stop_tick / per_len + 1;
      periods = (nin == 0 || sp < nin) ? sp : nin;
    end
    total = periods * per_len;
    $display("run %s: Q=%0d N=%0d blank=%0d stop_tick=%0d -> periods=%0d busy_cycles=%0d",
             tag, qin, nin, bin, stop_tick, periods, total);

    @(negedge clk_in);
    quarter_len_in = DIV_W'(qin);
    n_periods_in   = CNT_W'(nin);
    blank_in       = BLANK_W'(bin);
    start_in       = 1'b1;
    stop_in        = stop_with_start;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in       = 1'b0;
    stop_in        = (stop_tick == 0);
    // Inputs must be ignored once latched.
    quarter_len_in = DIV_W'($urandom_range(1, 50));
    n_periods_in   = CNT_W'($urandom_range(1, 50));
    blank_in       = BLANK_W'($urandom_range(0, 50));
    chk({tag, " c0 busy"}, 32'(busy_out), 0);

    for (int c = 1; c <= total; c++) begin
      @(negedge clk_in);
      t    = c - 1;
      tq   = t % qe;
      quad = (t / qe) % 4;
      per  = t / per_len;
      nm   = $sformatf("%s c%0d", tag, c);
      chk({nm, " busy"},  32'(busy_out), 1);
      chk({nm, " done"},  32'(done_out), 0);
      chk({nm, " quad"},  32'(quadrant_out), 32'(quad));
      chk({nm, " ref_i"}, 32'(ref_i_out), (quad < 2) ? 1 : 0);
      chk({nm, " ref_q"}, 32'(ref_q_out), (quad == 1 || quad == 2) ? 1 : 0);
      chk({nm, " sv"},    32'(sample_valid_out), (tq >= bin) ? 1 : 0);
      chk({nm, " pcnt"},  32'(period_cnt_out), 32'(per));
      stop_in = (c == stop_tick);
    end

    @(negedge clk_in);
    stop_in = 1'b0;
    nm = $sformatf("%s end", tag);
    chk({nm, " busy"},  32'(busy_out), 0);
    chk({nm, " done"},  32'(done_out), 1);
    chk({nm, " ref_i"}, 32'(ref_i_out), 0);
    chk({nm, " ref_q"}, 32'(ref_q_out), 0);
    chk({nm, " quad"},  32'(quadrant_out), 0);
    chk({nm, " sv"},    32'(sample_valid_out), 0);
    chk({nm, " pcnt"},  32'(period_cnt_out), 32'(periods));

    @(negedge clk_in);
    nm = $sformatf("%s post", tag);
    chk({nm, " done"}, 32'(done_out), 0);
    chk({nm, " busy"}, 32'(busy_out), 0);
    chk({nm, " pcnt"}, 32'(period_cnt_out), 32'(periods));
  endtask

  initial begin
    rst_in         = 1'b1;
    start_in       = 1'b0;
    stop_in        = 1'b0;
    quarter_len_in = '0;
    n_periods_in   = '0;
    blank_in       = '0;
    repeat (3) @(negedge clk_in);
    chk_idle_outputs("reset");
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_idle_outputs("idle");

    run_seq(4, 2, 1, -1, 1'b0, "q4n2b1");
    run_seq(0, 1, 0, -1, 1'b0, "q0n1");
    run_seq(8, 5, 0, 11, 1'b0, "q8stop");
    run_seq(4, 1, 4, -1, 1'b0, "blankall");
    run_seq(2, 3, 0, 7, 1'b0, "stoplastq3");
    run_seq(3, 1, 1, -1, 1'b1, "startstop");
`ifdef CHOPPER_CONTINUOUS_EN
    run_seq(2, 0, 0, 13, 1'b0, "n0cont");
`else
    run_seq(4, 0, 2, -1, 1'b0, "n0done");
`endif

    // Abort mid-q2 with an asynchronous reset.
    @(negedge clk_in);
    quarter_len_in = 16'd4;
    n_periods_in   = 16'd2;
    blank_in       = 8'd1;
    start_in       = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("rst pre busy", 32'(busy_out), 1);
    chk("rst pre quad", 32'(quadrant_out), 2);
    rst_in = 1'b1;
    #1;
    chk_idle_outputs("rst async");
    @(negedge clk_in);
    chk_idle_outputs("rst hold");
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_idle_outputs("rst release");
    $display("run rstmid: reset asserted at q2, outputs cleared");

    run_seq(4, 2, 1, -1, 1'b0, "afterrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
